// File: rtl/acu_seq_pkg.sv
// Shared types and widths for the ACU sequencer.
package acu_seq_pkg;
   localparam int ACU_W  = 16;
   localparam int BYTE_W = 8;
   localparam int HOLD_W = 4;

   typedef enum logic [2:0] {
      INIT, IDLE, LOAD_LO, LOAD_HI, WAIT, VALID
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter; the pointer remembers the last granted port.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   logic last;

   // On contention the port that did not win last time gets the grant.
   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              last <= 1'b0;
      else if (adv && |gnt)  last <= gnt[1];
   end
endmodule

// File: rtl/acu_seq.sv
// Arbitrates two requesters onto the ACU and sequences byte loads, output
// enable and the hold window for each granted address.
module acu_seq
   import acu_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter bit SKIP_HI     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ACU_W-1:0]  addr0,
   input  logic              req1,
   input  logic [ACU_W-1:0]  addr1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [BYTE_W-1:0] acu_d,
   output logic              acu_wl,
   output logic              acu_wh,
   output logic              acu_oe,
   output logic              acu_rst,
   output logic              busy
);
   state_t              state, state_nx;
   logic                live;
   logic                own;
   logic [ACU_W-1:0]    addr_q;
   logic [HOLD_W-1:0]   cnt;
   logic                hi_valid;
   logic [BYTE_W-1:0]   hi_cache;
   logic [1:0]          arb_gnt;
   logic                grant;
   logic                hi_hit;
   logic                owning;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({req1, req0}),
      .adv (grant),
      .gnt (arb_gnt)
   );

   assign grant  = live && (state == IDLE) && (|arb_gnt);
   assign hi_hit = SKIP_HI && hi_valid && (hi_cache == addr_q[ACU_W-1:BYTE_W]);
   assign owning = (state != INIT) && (state != IDLE);

   // live holds every output low while reset is asserted and makes the
   // post-reset INIT cycle a full clock long.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live     <= 1'b0;
         state    <= INIT;
         own      <= 1'b0;
         addr_q   <= '0;
         cnt      <= '0;
         hi_valid <= 1'b0;
         hi_cache <= '0;
      end else begin
         live  <= 1'b1;
         state <= state_nx;
         if (grant) begin
            own    <= arb_gnt[1];
            addr_q <= arb_gnt[1] ? addr1 : addr0;
         end
         if (live && state == INIT) begin
            hi_valid <= 1'b1;
            hi_cache <= '0;
         end
         if (state == LOAD_HI) begin
            hi_valid <= 1'b1;
            hi_cache <= addr_q[ACU_W-1:BYTE_W];
         end
         if (state == WAIT)                 cnt <= HOLD_W'(HOLD_CYCLES - 1);
         else if (state == VALID && cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      done0    = 1'b0;
      done1    = 1'b0;
      acu_d    = '0;
      acu_wl   = 1'b0;
      acu_wh   = 1'b0;
      acu_oe   = 1'b0;
      acu_rst  = 1'b0;
      if (live) begin
         busy = (state != IDLE);
         gnt0 = owning && !own;
         gnt1 = owning && own;
         case (state)
            INIT: begin
               acu_rst  = 1'b1;
               state_nx = IDLE;
            end
            IDLE: if (grant) state_nx = LOAD_LO;
            LOAD_LO: begin
               acu_wl   = 1'b1;
               acu_d    = addr_q[BYTE_W-1:0];
               state_nx = hi_hit ? WAIT : LOAD_HI;
            end
            LOAD_HI: begin
               acu_wh   = 1'b1;
               acu_d    = addr_q[ACU_W-1:BYTE_W];
               state_nx = WAIT;
            end
            WAIT: begin
               acu_oe   = 1'b1;
               state_nx = VALID;
            end
            VALID: begin
               acu_oe = 1'b1;
               if (cnt == '0) begin
                  done0    = !own;
                  done1    = own;
                  state_nx = IDLE;
               end
            end
            default: state_nx = INIT;
         endcase
      end
   end
endmodule
